stream_mux_nch: RTL

//   Parametrised N:1 streaming multiplexer; successor to the plain 2:1 combinational mux.

---
 rtl/stream_mux_nch.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/stream_mux_nch.sv
// N:1 packet-locked streaming multiplexer with fixed or round-robin channel selection
// and a single registered output stage.
module stream_mux_nch #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         cur_ch,
    output logic                     busy
);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    cur_ch_q, cur_ch_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic                cur_valid, cur_last, sel_valid;
    logic [DATA_W-1:0]   cur_data;
    logic                take, accept;
    logic                grant;
    logic [SEL_W-1:0]    grant_ch;
    logic                hi_hit, lo_hit;
    logic [SEL_W-1:0]    hi_ch, lo_ch;

    // Per-channel views of the locked channel and of the fixed-mode request.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_ch_q == SEL_W'(k)) begin
                cur_valid = in_valid[k];
                cur_last  = in_last[k];
                cur_data  = in_data[k*DATA_W +: DATA_W];
            end
            if (sel == SEL_W'(k)) begin
                sel_valid = in_valid[k];
            end
        end
    end

    // Round-robin: lowest valid channel above rr_ptr, else lowest valid channel overall.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_ch  = '0;
        lo_ch  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                lo_hit = 1'b1;
                lo_ch  = SEL_W'(k);
                if (SEL_W'(k) > rr_ptr_q) begin
                    hi_hit = 1'b1;
                    hi_ch  = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        grant    = 1'b0;
        grant_ch = '0;
        if (mode) begin
            grant    = lo_hit;
            grant_ch = hi_hit ? hi_ch : lo_ch;
        end else begin
            grant    = sel_valid;
            grant_ch = sel;
        end
    end

    assign take   = !out_valid_q || out_ready;
    assign accept = (state_q == StLock) && cur_valid && take;

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            in_ready[k] = (state_q == StLock) && (cur_ch_q == SEL_W'(k)) && take;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d  = StLock;
                    cur_ch_d = grant_ch;
                    rr_ptr_d = grant_ch;
                end
            end
            StLock: begin
                if (accept && cur_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register drains independently of the arbitration state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = cur_data;
            out_last_d  = cur_last;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_ch_q    <= '0;
            rr_ptr_q    <= SEL_W'(NUM_CH - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign cur_ch    = cur_ch_q;
    assign busy      = (state_q == StLock);

endmodule
